// File: rtl/vin_burst_pkg.sv
// Shared types and defaults for the vin burst generator.
package vin_burst_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_GAP_W   = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE, HI, LO, SAMPLE, STOP, FLUSH, WAIT, DONE
  } state_t;

  // The timer serves both the gap and the timeout, so it must hold
  // the larger of the two load values.
  function automatic int tmr_width(input int gap_w, input int timeout);
    int tw;
    tw = $clog2(timeout);
    return (gap_w > tw) ? gap_w : tw;
  endfunction

endpackage

// File: rtl/vin_gap_timer.sv
// Loadable down-counter shared between the LO gap and the WAIT timeout.
module vin_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= value;
    else if (dec && !expire) cnt <= cnt - W'(1);
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/vin_burst_gen.sv
// Emits N spaced vin pulses, samples the downstream count, then runs the
// stop / flush / acknowledge handshake and reports match or timeout.
module vin_burst_gen
  import vin_burst_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int GAP_W   = DEF_GAP_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [WIDTH-1:0] num_pulses,
  input  logic [GAP_W-1:0] gap,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             valid_in,
  output logic             vin,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             timeout,
  output logic [WIDTH-1:0] captured
);

  localparam int TW = tmr_width(GAP_W, TIMEOUT);

  state_t           state;
  logic [WIDTH-1:0] n_lat;
  logic [WIDTH-1:0] rem;
  logic [GAP_W-1:0] gap_lat;

  logic          tmr_load;
  logic          tmr_dec;
  logic          tmr_exp;
  logic [TW-1:0] tmr_val;

  // Loaded one cycle early (in HI / FLUSH) so LO lasts exactly gap cycles
  // and WAIT exactly TIMEOUT cycles.
  always_comb begin
    tmr_load = (state == HI) || (state == FLUSH);
    tmr_dec  = (state == LO) || (state == WAIT);
    tmr_val  = (state == HI) ? TW'(gap_lat - GAP_W'(1)) : TW'(TIMEOUT - 1);
  end

  vin_gap_timer #(.W(TW)) u_tmr (
    .clk    (clk),
    .rst    (res),
    .load   (tmr_load),
    .value  (tmr_val),
    .dec    (tmr_dec),
    .expire (tmr_exp)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= IDLE;
      n_lat    <= '0;
      rem      <= '0;
      gap_lat  <= '0;
      vin      <= 1'b0;
      stop     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      match    <= 1'b0;
      timeout  <= 1'b0;
      captured <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_lat    <= num_pulses;
            rem      <= num_pulses;
            gap_lat  <= (gap == '0) ? GAP_W'(1) : gap;
            match    <= 1'b0;
            timeout  <= 1'b0;
            captured <= '0;
            busy     <= 1'b1;
            if (num_pulses == '0) begin
              state <= SAMPLE;
            end else begin
              state <= HI;
              vin   <= 1'b1;
            end
          end
        end
        HI: begin
          rem   <= rem - WIDTH'(1);
          vin   <= 1'b0;
          state <= LO;
        end
        LO: begin
          if (tmr_exp) begin
            if (rem != '0) begin
              state <= HI;
              vin   <= 1'b1;
            end else begin
              state <= SAMPLE;
            end
          end
        end
        SAMPLE: begin
          captured <= cnt_in;
          stop     <= 1'b1;
          state    <= STOP;
        end
        STOP: begin
          vin   <= 1'b1;
          state <= FLUSH;
        end
        FLUSH: begin
          vin   <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // An acknowledge on the last timer cycle still counts as success.
          if (valid_in) begin
            match   <= (captured == n_lat);
            timeout <= 1'b0;
            stop    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (tmr_exp) begin
            match   <= 1'b0;
            timeout <= 1'b1;
            stop    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vin_burst_gen.sv
// Bench for vin_burst_gen: per-cycle waveform reference built from the
// command (pulses, gap, acknowledge delay) plus a behavioural pulse counter.
module tb_vin_burst_gen;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       res;
  logic       start;
  logic [7:0] num_pulses;
  logic [3:0] gap;
  logic [7:0] cnt_in;
  logic       valid_in;
  logic       vin, stop, busy, done, match, timeout;
  logic [7:0] captured;

  int errors = 0;
  int checks = 0;

  vin_burst_gen dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .num_pulses (num_pulses),
    .gap        (gap),
    .cnt_in     (cnt_in),
    .valid_in   (valid_in),
    .vin        (vin),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .match      (match),
    .timeout    (timeout),
    .captured   (captured)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // d: acknowledge arrives in WAIT cycle d+1 (d<0: never). frc>=0 forces cnt_in.
  task automatic run_cmd(input int n, input int g, input int d, input int frc, input bit inject);
    logic [3:0] exp_tr[$];   // {vin, stop, done, busy} per cycle
    int ge, w, w0, len, cnt, inj_at, exp_cap;
    bit to, exp_match;
    ge = (g == 0) ? 1 : g;
    to = (d < 0) || (d + 1 > TIMEOUT);
    w  = to ? TIMEOUT : d + 1;
    for (int i = 0; i < n; i++) begin
      exp_tr.push_back(4'b1001);
      for (int j = 0; j < ge; j++) exp_tr.push_back(4'b0001);
    end
    exp_tr.push_back(4'b0001);                       // sample
    exp_tr.push_back(4'b0101);                       // stop
    exp_tr.push_back(4'b1101);                       // flush pulse
    for (int j = 0; j < w; j++) exp_tr.push_back(4'b0101);
    exp_tr.push_back(4'b0011);                       // done
    w0      = n * (1 + ge) + 3;
    len     = exp_tr.size();
    exp_cap = (frc >= 0) ? frc : n;
    exp_match = !to && (exp_cap[7:0] == n[7:0]);
    inj_at  = inject ? int'($urandom_range(0, len - 2)) : -1;

    chk("idle_busy", {31'd0, busy}, 32'd0);
    cnt        = 0;
    start      = 1'b1;
    num_pulses = n[7:0];
    gap        = g[3:0];
    cnt_in     = (frc >= 0) ? frc[7:0] : 8'd0;
    valid_in   = 1'b0;
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("trace n=%0d g=%0d d=%0d i=%0d", n, g, d, i),
          {28'd0, vin, stop, done, busy}, {28'd0, exp_tr[i]});
      if (vin && !stop) cnt++;
      cnt_in = (frc >= 0) ? frc[7:0] : cnt[7:0];
      start  = (i == inj_at);
      if (start) begin
        num_pulses = 8'($urandom);
        gap        = 4'($urandom);
      end
      if (i < w0) valid_in = ($urandom_range(0, 3) == 0);
      else        valid_in = (d >= 0) && (i == w0 + d);
      if (i == len - 1) begin
        chk("captured", {24'd0, captured}, 32'(exp_cap));
        chk("match", {31'd0, match}, {31'd0, exp_match});
        chk("timeout", {31'd0, timeout}, {31'd0, to});
      end
      @(negedge clk);
    end
    start    = 1'b0;
    valid_in = 1'b0;
    chk("post_done", {30'd0, done, busy}, 32'd0);
    chk("hold", {22'd0, captured, match, timeout}, {22'd0, exp_cap[7:0], exp_match, to});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; start = 1'b0; num_pulses = '0; gap = '0; cnt_in = '0; valid_in = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {18'd0, vin, stop, busy, done, match, timeout, captured}, 32'd0);
    res = 1'b0;
    @(negedge clk);

    run_cmd(5, 2, 0, -1, 1'b0);
    run_cmd(0, 3, 0, -1, 1'b0);
    run_cmd(3, 0, 0, -1, 1'b0);
    run_cmd(2, 1, -1, -1, 1'b0);      // no acknowledge: timeout
    run_cmd(6, 1, 0, 7, 1'b0);        // downstream reports the wrong count
    run_cmd(2, 1, 15, -1, 1'b0);      // acknowledge on the last WAIT cycle
    run_cmd(2, 1, 16, -1, 1'b0);      // one cycle too late
    run_cmd(255, 1, 2, -1, 1'b1);     // maximum count, stray start mid-burst

    // reset during the second HI of an N=4 burst
    start = 1'b1; num_pulses = 8'd4; gap = 4'd1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_vin", {31'd0, vin}, 32'd1);
    res = 1'b1;
    #1;
    chk("rst_async", {28'd0, vin, stop, busy, done}, 32'd0);
    @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_done", {28'd0, vin, stop, busy, done}, 32'd0);
    end
    run_cmd(1, 2, 0, -1, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int n, g, d, frc;
      n   = int'($urandom_range(0, 12));
      g   = int'($urandom_range(0, 15));
      d   = int'($urandom_range(0, 19)) - 1;
      frc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_cmd(n, g, d, frc, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
